distance_calc_seq: RTL and testbench
====================================

// Module: distance_calc_seq
// PURPOSE
//  Sequential, parametrised distance calculator for redundant weight pairs: from pair indices and layer shape
//  (OW, FW, S) computes output-pixel distance dr and a per-column exception mask. Replaces combinational
//  dividers with one shared serial divider. Adds valid/ready handshake, index-order swap and div-by-zero trap.
//  Sits between the redundancy detector (pair producer) and the output-reuse controller (dr/except consumer).
// PARAMETERS
//  WORD_WIDTH  8    width of idx1/idx2/ow/fw/st and internal quotients/moduli (W)
//  DIST_WIDTH  7    width of dr; dr >= 2**DIST_WIDTH is overflow
//  MAX_C_SIZE  128  output columns covered by except mask (C); column counter is $clog2(C) bits
// PORTS
//  clk         in   1     clock, all state on rising edge
//  reset_n     in   1     asynchronous active-low reset
//  in_valid    in   1     request valid
//  in_ready    out  1     block idle, request accepted when in_valid&in_ready
//  idx1, idx2  in   W     pair indices in lowered filter (any order)
//  ow, fw, st  in   W     output width, filter width, stride
//  out_valid   out  1     result valid, held until out_ready
//  out_ready   in   1     consumer accepts result
//  dr          out  DIST_WIDTH  distance of redundant output pixel
//  except      out  C     bit c=1: column c cannot reuse (exception)
//  exc_ovf / exc_stride / exc_div0 / exc_order  out 1 each  cause flags
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; dr=0; except=0; all exc_* =0. Reset mid-operation aborts
//   the request with no output; in_ready=1 in the first cycle after reset_n rises.
//  Accept (cycle T): register operands; if idx1>idx2 swap them and set exc_order. If fw==0|st==0|ow==0:
//   go to DONE, out_valid=1 at T+1, exc_div0=1, except=all ones, dr=0, other flags 0 (except exc_order).
//  FSM: IDLE -> DIV1(W) -> DIV2(W) -> DVS(W) -> DHS(W) -> MUL(1) -> DR(2W) -> COL(C) -> DONE -> IDLE.
//   DIVn are one quotient bit/cycle restoring divisions on the shared divider:
//   DIV1: do1,mo1 = idx1 /,% fw   DIV2: do2,mo2 = idx2 /,% fw   dv=do2-do1, dh=mo2-mo1, d=idx2-idx1 (W bits)
//   DVS: dv % st   DHS: q=dh/st, dh%st   MUL: dr_nst = (ow-fw)*dv + d, 2W bits, ow-fw wraps mod 2**W
//   DR: dr_raw = dr_nst / {W'b0,st} (2W-bit divide)
//   COL: c counts 0..C-1, oc=c mod ow via wrapping counter (oc->0 after ow-1); one bit per cycle:
//    except[c] = (oc < q) | (((oc-q) mod 2**W) >= ow) | exc_ovf | exc_stride.
//  exc_ovf = |dr_raw[2W-1:DIST_WIDTH]; exc_stride = (dv%st!=0)|(dh%st!=0); dr = dr_raw[DIST_WIDTH-1:0].
//  Normal latency: out_valid first high at T+6W+C+2 (T+178 at defaults); exact, bench checks it.
//  in_ready=1 only in IDLE; in_valid outside IDLE is ignored (not queued).
//  DONE: out_valid=1, all outputs stable until out_valid&out_ready; next cycle IDLE, out_valid=0,
//   in_ready=1; dr/except/flags keep last values until next result. No back-to-back accept in DONE cycle.
// TESTING (defaults W=8, DIST=7, C=128)
//  idx1=1,idx2=4,ow=6,fw=3,st=1 -> dr=6, except=0, all flags 0, out_valid at T+178
//  same with st=2 -> dr=3, exc_stride=1, except=all ones
//  idx1=0,idx2=2,ow=6,fw=3,st=1 -> dr=2, except[c]=1 exactly when c%6 in {0,1}, flags 0
//  idx1=0,idx2=3,ow=200,fw=3,st=1 -> dr_raw=200, dr=72, exc_ovf=1, except=all ones
//  fw=0 (any idx) -> out_valid at T+1, exc_div0=1, dr=0, except=all ones; idx1=4,idx2=1 case 1 -> dr=6, exc_order=1
//  out_ready low 10 cycles in DONE -> outputs stable, in_ready=0; reset_n pulse in DR -> outputs 0, IDLE

Source files
------------

// File: rtl/distance_calc_seq_if.sv
// Request/result bundle between the redundancy detector (master) and the
// distance calculator (slave). Signal prefixes are from the calculator's side.
interface distance_calc_seq_if #(
  parameter int WORD_WIDTH = 8,
  parameter int DIST_WIDTH = 7,
  parameter int MAX_C_SIZE = 128
);
  logic                  i_in_valid;
  logic                  o_in_ready;
  logic [WORD_WIDTH-1:0] i_idx1;
  logic [WORD_WIDTH-1:0] i_idx2;
  logic [WORD_WIDTH-1:0] i_ow;
  logic [WORD_WIDTH-1:0] i_fw;
  logic [WORD_WIDTH-1:0] i_st;
  logic                  o_out_valid;
  logic                  i_out_ready;
  logic [DIST_WIDTH-1:0] o_dr;
  logic [MAX_C_SIZE-1:0] o_except;
  logic                  o_exc_ovf;
  logic                  o_exc_stride;
  logic                  o_exc_div0;
  logic                  o_exc_order;

  modport slave (
    input  i_in_valid, i_idx1, i_idx2, i_ow, i_fw, i_st, i_out_ready,
    output o_in_ready, o_out_valid, o_dr, o_except,
           o_exc_ovf, o_exc_stride, o_exc_div0, o_exc_order
  );

  modport master (
    output i_in_valid, i_idx1, i_idx2, i_ow, i_fw, i_st, i_out_ready,
    input  o_in_ready, o_out_valid, o_dr, o_except,
           o_exc_ovf, o_exc_stride, o_exc_div0, o_exc_order
  );
endinterface

// File: rtl/distance_calc_seq.sv
// Sequential distance calculator for redundant weight pairs. One shared
// restoring divider (one quotient bit per cycle) replaces all dividers; the
// exception mask is then built one output column per cycle.
module distance_calc_seq #(
  parameter int WORD_WIDTH = 8,
  parameter int DIST_WIDTH = 7,
  parameter int MAX_C_SIZE = 128
) (
  input logic                clk,
  input logic                reset_n,
  distance_calc_seq_if.slave bus
);
  localparam int W     = WORD_WIDTH;
  localparam int W2    = 2 * WORD_WIDTH;
  localparam int DW    = DIST_WIDTH;
  localparam int C     = MAX_C_SIZE;
  localparam int CNT_W = $clog2(W2);
  localparam int COL_W = $clog2(C);
  localparam logic [CNT_W-1:0] LAST_W   = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] LAST_2W  = CNT_W'(W2 - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(C - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_DIV1, S_DIV2, S_DVS, S_DHS, S_MUL, S_DR, S_COL, S_DONE
  } state_t;

  state_t r_state, w_nextState;

  logic [W-1:0]     r_idx1, r_idx2, r_ow, r_fw, r_st;
  logic             r_order;
  logic [W2-1:0]    r_quo;
  logic [W-1:0]     r_rem;
  logic [CNT_W-1:0] r_bitCnt;
  logic [W-1:0]     r_do1, r_mo1, r_dv, r_dh, r_d, r_q;
  logic             r_strideExc, r_ovfExc;
  logic [DW-1:0]    r_drWork;
  logic [COL_W-1:0] r_col;
  logic [W-1:0]     r_oc;
  logic [C-1:0]     r_exceptWork;

  logic [DW-1:0]    r_outDr;
  logic [C-1:0]     r_outExcept;
  logic             r_outOvf, r_outStride, r_outDiv0, r_outOrder;

  logic             w_accept, w_div0, w_swap;
  logic [W-1:0]     w_lo, w_hi, w_divisor;
  logic [W:0]       w_remShift;
  logic             w_geq;
  logic [W-1:0]     w_remNext;
  logic [W2-1:0]    w_quoNext;
  logic [W-1:0]     w_dv, w_dh, w_owMinusFw, w_ocMinusQ;
  logic [W2-1:0]    w_drNst;
  logic             w_colBit;
  logic [C-1:0]     w_exceptFinal;

  assign w_accept = bus.i_in_valid && (r_state == S_IDLE);
  assign w_div0   = (bus.i_fw == '0) || (bus.i_st == '0) || (bus.i_ow == '0);
  assign w_swap   = bus.i_idx1 > bus.i_idx2;
  assign w_lo     = w_swap ? bus.i_idx2 : bus.i_idx1;
  assign w_hi     = w_swap ? bus.i_idx1 : bus.i_idx2;

  // The column-position divisions use fw, every later division uses st.
  assign w_divisor  = (r_state == S_DIV1 || r_state == S_DIV2) ? r_fw : r_st;
  assign w_remShift = {r_rem, r_quo[W2-1]};
  assign w_geq      = w_remShift >= {1'b0, w_divisor};
  assign w_remNext  = W'(w_geq ? (w_remShift - {1'b0, w_divisor}) : w_remShift);
  assign w_quoNext  = {r_quo[W2-2:0], w_geq};

  assign w_dv        = w_quoNext[W-1:0] - r_do1;
  assign w_dh        = w_remNext - r_mo1;
  assign w_owMinusFw = r_ow - r_fw;
  assign w_drNst     = ({{W{1'b0}}, w_owMinusFw} * {{W{1'b0}}, r_dv}) + {{W{1'b0}}, r_d};

  assign w_ocMinusQ = r_oc - r_q;
  assign w_colBit   = (r_oc < r_q) || (w_ocMinusQ >= r_ow) || r_ovfExc || r_strideExc;

  // Column c's bit enters at the top and ends at bit c after the last shift.
  always_comb begin
    w_exceptFinal        = r_exceptWork >> 1;
    w_exceptFinal[C-1]   = w_colBit;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  // Next-state sequencing through the divide, multiply and column phases.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (bus.i_in_valid) w_nextState = w_div0 ? S_DONE : S_DIV1;
      S_DIV1: if (r_bitCnt == LAST_W) w_nextState = S_DIV2;
      S_DIV2: if (r_bitCnt == LAST_W) w_nextState = S_DVS;
      S_DVS:  if (r_bitCnt == LAST_W) w_nextState = S_DHS;
      S_DHS:  if (r_bitCnt == LAST_W) w_nextState = S_MUL;
      S_MUL:  w_nextState = S_DR;
      S_DR:   if (r_bitCnt == LAST_2W) w_nextState = S_COL;
      S_COL:  if (r_col == LAST_COL) w_nextState = S_DONE;
      S_DONE: if (bus.i_out_ready) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Datapath: operand capture, shared divider steps, result publication.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx1 <= '0; r_idx2 <= '0; r_ow <= '0; r_fw <= '0; r_st <= '0;
      r_order <= 1'b0; r_quo <= '0; r_rem <= '0; r_bitCnt <= '0;
      r_do1 <= '0; r_mo1 <= '0; r_dv <= '0; r_dh <= '0; r_d <= '0; r_q <= '0;
      r_strideExc <= 1'b0; r_ovfExc <= 1'b0; r_drWork <= '0;
      r_col <= '0; r_oc <= '0; r_exceptWork <= '0;
      r_outDr <= '0; r_outExcept <= '0;
      r_outOvf <= 1'b0; r_outStride <= 1'b0; r_outDiv0 <= 1'b0; r_outOrder <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx1 <= w_lo; r_idx2 <= w_hi;
            r_ow <= bus.i_ow; r_fw <= bus.i_fw; r_st <= bus.i_st;
            r_order <= w_swap;
            r_quo <= {w_lo, {W{1'b0}}}; r_rem <= '0; r_bitCnt <= '0;
            if (w_div0) begin
              r_outDr <= '0; r_outExcept <= '1;
              r_outOvf <= 1'b0; r_outStride <= 1'b0;
              r_outDiv0 <= 1'b1; r_outOrder <= w_swap;
            end
          end
        end
        S_DIV1, S_DIV2, S_DVS, S_DHS, S_DR: begin
          r_quo <= w_quoNext; r_rem <= w_remNext;
          r_bitCnt <= r_bitCnt + CNT_W'(1);
          if (r_state == S_DIV1 && r_bitCnt == LAST_W) begin
            r_do1 <= w_quoNext[W-1:0]; r_mo1 <= w_remNext;
            r_quo <= {r_idx2, {W{1'b0}}}; r_rem <= '0; r_bitCnt <= '0;
          end
          if (r_state == S_DIV2 && r_bitCnt == LAST_W) begin
            r_dv <= w_dv; r_dh <= w_dh; r_d <= r_idx2 - r_idx1;
            r_quo <= {w_dv, {W{1'b0}}}; r_rem <= '0; r_bitCnt <= '0;
          end
          if (r_state == S_DVS && r_bitCnt == LAST_W) begin
            r_strideExc <= (w_remNext != '0);
            r_quo <= {r_dh, {W{1'b0}}}; r_rem <= '0; r_bitCnt <= '0;
          end
          if (r_state == S_DHS && r_bitCnt == LAST_W) begin
            r_q <= w_quoNext[W-1:0];
            r_strideExc <= r_strideExc || (w_remNext != '0);
          end
          if (r_state == S_DR && r_bitCnt == LAST_2W) begin
            r_drWork <= w_quoNext[DW-1:0];
            r_ovfExc <= |w_quoNext[W2-1:DW];
            r_col <= '0; r_oc <= '0;
          end
        end
        S_MUL: begin
          r_quo <= w_drNst; r_rem <= '0; r_bitCnt <= '0;
        end
        S_COL: begin
          r_exceptWork <= w_exceptFinal;
          r_col <= r_col + COL_W'(1);
          r_oc <= (r_oc == r_ow - W'(1)) ? '0 : r_oc + W'(1);
          if (r_col == LAST_COL) begin
            r_outDr <= r_drWork; r_outExcept <= w_exceptFinal;
            r_outOvf <= r_ovfExc; r_outStride <= r_strideExc;
            r_outDiv0 <= 1'b0; r_outOrder <= r_order;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_in_ready   = (r_state == S_IDLE);
  assign bus.o_out_valid  = (r_state == S_DONE);
  assign bus.o_dr         = r_outDr;
  assign bus.o_except     = r_outExcept;
  assign bus.o_exc_ovf    = r_outOvf;
  assign bus.o_exc_stride = r_outStride;
  assign bus.o_exc_div0   = r_outDiv0;
  assign bus.o_exc_order  = r_outOrder;
endmodule

// File: tb/tb_distance_calc_seq.sv
// Testbench for distance_calc_seq: directed pairs, random pairs against an
// arithmetic reference model, divide-by-zero trap, stalls and mid-op reset.
module tb_distance_calc_seq;
  localparam int W   = 8;
  localparam int DW  = 7;
  localparam int C   = 128;
  localparam int LAT = 6 * W + C + 2;
  localparam int BUDGET = 400;

  typedef struct {
    logic [DW-1:0] dr;
    logic [C-1:0]  exc;
    logic [3:0]    flags;   // {ovf, stride, div0, order}
  } result_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  distance_calc_seq_if #(.WORD_WIDTH(W), .DIST_WIDTH(DW), .MAX_C_SIZE(C)) ifc ();

  distance_calc_seq #(.WORD_WIDTH(W), .DIST_WIDTH(DW), .MAX_C_SIZE(C)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the pair geometry.
  function automatic result_t model(input int a0, input int b0, input int ow, input int fw, input int st);
    result_t r;
    int a, b, dv, dh, d, q, nst, raw, oc, ocq;
    bit ovf, stride;
    a = (a0 < b0) ? a0 : b0;
    b = (a0 < b0) ? b0 : a0;
    if (fw == 0 || st == 0 || ow == 0) begin
      r.dr = '0; r.exc = '1; r.flags = {1'b0, 1'b0, 1'b1, a0 > b0};
      return r;
    end
    dv = ((b / fw) - (a / fw)) & 255;
    dh = ((b % fw) - (a % fw)) & 255;
    d  = b - a;
    stride = ((dv % st) != 0) || ((dh % st) != 0);
    q   = dh / st;
    nst = ((((ow - fw) & 255) * dv) + d) & 65535;
    raw = nst / st;
    ovf = raw >= (1 << DW);
    r.dr = DW'(raw % (1 << DW));
    for (int c = 0; c < C; c++) begin
      oc  = c % ow;
      ocq = (oc - q) & 255;
      r.exc[c] = (oc < q) || (ocq >= ow) || ovf || stride;
    end
    r.flags = {ovf, stride, 1'b0, a0 > b0};
    return r;
  endfunction

  // Presents one request and waits for its result; latency counts cycles after the accept cycle.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] o,
                               input logic [W-1:0] f, input logic [W-1:0] s,
                               output int latency, output bit timedOut);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    ifc.i_idx1 = a; ifc.i_idx2 = b; ifc.i_ow = o; ifc.i_fw = f; ifc.i_st = s;
    ifc.i_in_valid = 1'b1;
    while (ifc.o_in_ready !== 1'b1 && waitCnt < BUDGET) begin
      @(negedge clk);
      waitCnt++;
    end
    @(posedge clk);
    #1 ifc.i_in_valid = 1'b0;
    latency = 1;
    @(negedge clk);
    while (ifc.o_out_valid !== 1'b1 && latency < BUDGET) begin
      @(negedge clk);
      latency++;
    end
    timedOut = (ifc.o_out_valid !== 1'b1) || (waitCnt >= BUDGET);
  endtask

  // Takes the pending result with a one-cycle out_ready pulse.
  task automatic consume();
    @(negedge clk);
    ifc.i_out_ready = 1'b1;
    @(posedge clk);
    #1 ifc.i_out_ready = 1'b0;
  endtask

  // Reset state of every output, and readiness right after release.
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ifc.o_in_ready !== 1'b1 || ifc.o_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b, want 1 0", ifc.o_in_ready, ifc.o_out_valid);
    end
    checks++;
    if (ifc.o_dr !== '0 || ifc.o_except !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: dr=%0d except=%h, want 0 0", ifc.o_dr, ifc.o_except);
    end
    checks++;
    if ({ifc.o_exc_ovf, ifc.o_exc_stride, ifc.o_exc_div0, ifc.o_exc_order} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b%b%b%b, want 0000", ifc.o_exc_ovf, ifc.o_exc_stride, ifc.o_exc_div0, ifc.o_exc_order);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ifc.o_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: in_ready=%b, want 1", ifc.o_in_ready);
    end
  endtask

  // Worked examples with known distances.
  task automatic test_directed();
    logic [W-1:0]  va[5], vb[5], vo[5], vf[5], vs[5];
    logic [DW-1:0] vdr[5];
    result_t exp;
    int lat;
    bit to;
    va = '{8'd1, 8'd1, 8'd0, 8'd0,   8'd4};
    vb = '{8'd4, 8'd4, 8'd2, 8'd3,   8'd1};
    vo = '{8'd6, 8'd6, 8'd6, 8'd200, 8'd6};
    vf = '{8'd3, 8'd3, 8'd3, 8'd3,   8'd3};
    vs = '{8'd1, 8'd2, 8'd1, 8'd1,   8'd1};
    vdr = '{7'd6, 7'd3, 7'd2, 7'd72, 7'd6};
    for (int i = 0; i < 5; i++) begin
      exp = model(int'(va[i]), int'(vb[i]), int'(vo[i]), int'(vf[i]), int'(vs[i]));
      applyStimulus(va[i], vb[i], vo[i], vf[i], vs[i], lat, to);
      checks++;
      if (to || lat != LAT) begin
        errors++;
        $display("[TB] FAIL directed%0d_latency: got %0d (timeout=%0b), want %0d", i, lat, to, LAT);
      end
      checks++;
      if (ifc.o_dr !== vdr[i]) begin
        errors++;
        $display("[TB] FAIL directed%0d_dr: got %0d, want %0d", i, ifc.o_dr, vdr[i]);
      end
      checks++;
      if (ifc.o_except !== exp.exc) begin
        errors++;
        $display("[TB] FAIL directed%0d_except: got %h, want %h", i, ifc.o_except, exp.exc);
      end
      checks++;
      if ({ifc.o_exc_ovf, ifc.o_exc_stride, ifc.o_exc_div0, ifc.o_exc_order} !== exp.flags) begin
        errors++;
        $display("[TB] FAIL directed%0d_flags: got %b%b%b%b, want %b", i, ifc.o_exc_ovf, ifc.o_exc_stride, ifc.o_exc_div0, ifc.o_exc_order, exp.flags);
      end
      consume();
      @(negedge clk);
      checks++;
      if (ifc.o_in_ready !== 1'b1 || ifc.o_out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL directed%0d_release: in_ready=%b out_valid=%b, want 1 0", i, ifc.o_in_ready, ifc.o_out_valid);
      end
    end
  endtask

  // Zero fw, st or ow short-circuits to a one-cycle trap result.
  task automatic test_div0();
    logic [W-1:0] a, b, o, f, s;
    result_t exp;
    int lat;
    bit to;
    for (int i = 0; i < 3; i++) begin
      a = W'($urandom_range(0, 255)); b = W'($urandom_range(0, 255));
      o = (i == 2) ? 8'd0 : 8'd6;
      f = (i == 0) ? 8'd0 : 8'd3;
      s = (i == 1) ? 8'd0 : 8'd1;
      exp = model(int'(a), int'(b), int'(o), int'(f), int'(s));
      applyStimulus(a, b, o, f, s, lat, to);
      checks++;
      if (to || lat != 1) begin
        errors++;
        $display("[TB] FAIL div0_%0d_latency: got %0d (timeout=%0b), want 1", i, lat, to);
      end
      checks++;
      if (ifc.o_dr !== exp.dr || ifc.o_except !== exp.exc) begin
        errors++;
        $display("[TB] FAIL div0_%0d_data: dr=%0d except=%h, want %0d %h", i, ifc.o_dr, ifc.o_except, exp.dr, exp.exc);
      end
      checks++;
      if ({ifc.o_exc_ovf, ifc.o_exc_stride, ifc.o_exc_div0, ifc.o_exc_order} !== exp.flags) begin
        errors++;
        $display("[TB] FAIL div0_%0d_flags: got %b%b%b%b, want %b", i, ifc.o_exc_ovf, ifc.o_exc_stride, ifc.o_exc_div0, ifc.o_exc_order, exp.flags);
      end
      consume();
    end
  endtask

  // Random geometries, biased toward small strides and filter widths.
  task automatic test_random();
    logic [W-1:0] a, b, o, f, s;
    result_t exp;
    int lat;
    bit to;
    for (int i = 0; i < 25; i++) begin
      a = W'($urandom_range(0, 255)); b = W'($urandom_range(0, 255));
      f = W'($urandom_range(1, 12));
      s = W'($urandom_range(1, 3));
      o = (i % 2 == 0) ? W'(int'(f) + $urandom_range(0, 10)) : W'($urandom_range(1, 255));
      exp = model(int'(a), int'(b), int'(o), int'(f), int'(s));
      applyStimulus(a, b, o, f, s, lat, to);
      checks++;
      if (to || lat != LAT || ifc.o_dr !== exp.dr || ifc.o_except !== exp.exc ||
          {ifc.o_exc_ovf, ifc.o_exc_stride, ifc.o_exc_div0, ifc.o_exc_order} !== exp.flags) begin
        errors++;
        $display("[TB] FAIL random%0d (%0d,%0d,%0d,%0d,%0d): lat=%0d dr=%0d flags=%b%b%b%b except=%h, want lat=%0d dr=%0d flags=%b except=%h",
                 i, a, b, o, f, s, lat, ifc.o_dr, ifc.o_exc_ovf, ifc.o_exc_stride, ifc.o_exc_div0, ifc.o_exc_order,
                 ifc.o_except, LAT, exp.dr, exp.flags, exp.exc);
      end
      consume();
    end
  endtask

  // Stalled result stays stable, DONE never accepts, nothing is queued.
  task automatic test_backpressure();
    result_t exp;
    int lat;
    bit to, bad;
    exp = model(3, 9, 10, 4, 1);
    applyStimulus(8'd3, 8'd9, 8'd10, 8'd4, 8'd1, lat, to);
    checks++;
    if (to || lat != LAT) begin
      errors++;
      $display("[TB] FAIL stall_latency: got %0d (timeout=%0b), want %0d", lat, to, LAT);
    end
    ifc.i_idx1 = 8'd7; ifc.i_idx2 = 8'd20; ifc.i_in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (ifc.o_out_valid !== 1'b1 || ifc.o_in_ready !== 1'b0 || ifc.o_dr !== exp.dr || ifc.o_except !== exp.exc) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: out_valid=%b in_ready=%b dr=%0d, want 1 0 %0d", k, ifc.o_out_valid, ifc.o_in_ready, ifc.o_dr, exp.dr);
      end
    end
    consume();
    @(negedge clk);
    checks++;
    if (ifc.o_in_ready !== 1'b1 || ifc.o_out_valid !== 1'b0 || ifc.o_dr !== exp.dr) begin
      errors++;
      $display("[TB] FAIL stall_release: in_ready=%b out_valid=%b dr=%0d, want 1 0 %0d", ifc.o_in_ready, ifc.o_out_valid, ifc.o_dr, exp.dr);
    end
    ifc.i_in_valid = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ifc.o_in_ready !== 1'b1 || ifc.o_out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL stall_idle_after: block left IDLE without a request (got 1, want 0)");
    end
  endtask

  // in_valid held while busy with different operands is ignored.
  task automatic test_back_to_back();
    result_t exp;
    int lat;
    bit bad;
    exp = model(2, 17, 9, 5, 1);
    @(negedge clk);
    ifc.i_idx1 = 8'd2; ifc.i_idx2 = 8'd17; ifc.i_ow = 8'd9; ifc.i_fw = 8'd5; ifc.i_st = 8'd1;
    ifc.i_in_valid = 1'b1;
    @(posedge clk);
    #1 ifc.i_idx1 = 8'd100; ifc.i_idx2 = 8'd3; ifc.i_st = 8'd2;
    bad = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      lat = k;
      if (ifc.o_in_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL busy_ready: in_ready seen 1 while busy, want 0");
    end
    ifc.i_in_valid = 1'b0;
    while (ifc.o_out_valid !== 1'b1 && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != LAT || ifc.o_dr !== exp.dr || ifc.o_except !== exp.exc ||
        {ifc.o_exc_ovf, ifc.o_exc_stride, ifc.o_exc_div0, ifc.o_exc_order} !== exp.flags) begin
      errors++;
      $display("[TB] FAIL busy_result: lat=%0d dr=%0d except=%h, want lat=%0d dr=%0d except=%h", lat, ifc.o_dr, ifc.o_except, LAT, exp.dr, exp.exc);
    end
    consume();
  endtask

  // Reset pulse during the long division aborts the request and clears outputs.
  task automatic test_reset_mid_op();
    bit bad;
    @(negedge clk);
    ifc.i_idx1 = 8'd1; ifc.i_idx2 = 8'd4; ifc.i_ow = 8'd6; ifc.i_fw = 8'd3; ifc.i_st = 8'd1;
    ifc.i_in_valid = 1'b1;
    @(posedge clk);
    #1 ifc.i_in_valid = 1'b0;
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (ifc.o_dr !== '0 || ifc.o_except !== '0 || ifc.o_out_valid !== 1'b0 || ifc.o_in_ready !== 1'b1 ||
        {ifc.o_exc_ovf, ifc.o_exc_stride, ifc.o_exc_div0, ifc.o_exc_order} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midreset_clear: dr=%0d except=%h valid=%b ready=%b, want 0 0 0 1", ifc.o_dr, ifc.o_except, ifc.o_out_valid, ifc.o_in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ifc.o_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_ready: in_ready=%b, want 1", ifc.o_in_ready);
    end
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (ifc.o_out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL midreset_no_output: aborted request produced out_valid=1, want 0");
    end
  endtask

  // Hard stop if something hangs beyond every bounded wait.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    ifc.i_in_valid = 1'b0; ifc.i_out_ready = 1'b0;
    ifc.i_idx1 = '0; ifc.i_idx2 = '0; ifc.i_ow = '0; ifc.i_fw = '0; ifc.i_st = '0;
    test_reset();
    test_directed();
    test_div0();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
